// File: rtl/sr_ff_checker.sv
// Run-time monitor for a clocked S-R flip-flop. Predicts Q from the sampled
// S/R command and checks the flip-flop's Q/QBAR response one enabled edge later.
// Flags mismatches, complement violations and forbidden S=R=1 commands.
module sr_ff_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qbar,
  output logic             pred_q,
  output logic             known,
  output logic             mismatch,
  output logic             compl_err,
  output logic             forbidden,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] forb_cnt,
  output logic             sticky_err
);

  typedef enum logic [1:0] {
    StUnknown = 2'd0,
    StKnown   = 2'd1,
    StInvalid = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic             pred_val_q, pred_val_d;
  logic             mism_q, mism_d;
  logic             compl_q, compl_d;
  logic             forb_q, forb_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] forb_cnt_q, forb_cnt_d;
  logic             sticky_q, sticky_d;

  // Next-state: FSM/prediction update, checks and counter/sticky bookkeeping.
  always_comb begin
    state_d    = state_q;
    pred_val_d = pred_val_q;
    mism_d     = 1'b0;
    compl_d    = 1'b0;
    forb_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    forb_cnt_d = forb_cnt_q;
    sticky_d   = sticky_q;

    if (en) begin
      // Checks use the state/prediction from the previous enabled edge.
      mism_d  = (state_q == StKnown) && (q != pred_val_q);
      compl_d = (state_q != StInvalid) && (q == qbar);
      forb_d  = s & r;

      case ({s, r})
        2'b10: begin
          state_d    = StKnown;
          pred_val_d = 1'b1;
        end
        2'b01: begin
          state_d    = StKnown;
          pred_val_d = 1'b0;
        end
        2'b11: state_d = StInvalid;  // prediction held but meaningless
        default: ;                   // hold
      endcase
    end

    // Clear wins over any increment or sticky set on the same edge.
    if (clr) begin
      err_cnt_d  = '0;
      forb_cnt_d = '0;
      sticky_d   = 1'b0;
    end else begin
      if (mism_d && (err_cnt_q != CntMax)) err_cnt_d = err_cnt_q + 1'b1;
      if (forb_d && (forb_cnt_q != CntMax)) forb_cnt_d = forb_cnt_q + 1'b1;
      if (mism_d || compl_d) sticky_d = 1'b1;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StUnknown;
      pred_val_q <= 1'b0;
      mism_q     <= 1'b0;
      compl_q    <= 1'b0;
      forb_q     <= 1'b0;
      err_cnt_q  <= '0;
      forb_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pred_val_q <= pred_val_d;
      mism_q     <= mism_d;
      compl_q    <= compl_d;
      forb_q     <= forb_d;
      err_cnt_q  <= err_cnt_d;
      forb_cnt_q <= forb_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign pred_q     = pred_val_q;
  assign known      = (state_q == StKnown);
  assign mismatch   = mism_q;
  assign compl_err  = compl_q;
  assign forbidden  = forb_q;
  assign err_cnt    = err_cnt_q;
  assign forb_cnt   = forb_cnt_q;
  assign sticky_err = sticky_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Directed bench for sr_ff_checker: a table of per-cycle vectors with
// hand-computed responses, plus a hand-written mid-cycle reset sequence.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_sr_ff_checker;

  logic clk = 1'b0;
  logic rst_n, en, clr, s, r, q, qbar;

  logic       pred_q, known, mismatch, compl_err, forbidden, sticky_err;
  logic [7:0] err_cnt, forb_cnt;
  logic       pred_q2, known2, mismatch2, compl_err2, forbidden2, sticky_err2;
  logic [1:0] err_cnt2, forb_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sr_ff_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
    .pred_q(pred_q), .known(known), .mismatch(mismatch), .compl_err(compl_err),
    .forbidden(forbidden), .err_cnt(err_cnt), .forb_cnt(forb_cnt), .sticky_err(sticky_err)
  );

  sr_ff_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
    .pred_q(pred_q2), .known(known2), .mismatch(mismatch2), .compl_err(compl_err2),
    .forbidden(forbidden2), .err_cnt(err_cnt2), .forb_cnt(forb_cnt2),
    .sticky_err(sticky_err2)
  );

  typedef struct {
    logic       en, clr, s, r, q, qbar;
    logic       known, pred, mism, compl, forb;
    logic [7:0] err, err2, fcnt;
    logic       sticky;
  } vec_t;

  function automatic vec_t mk(input logic e, c, si, ri, qi, qbi,
                              input logic k, p, m, ce, f,
                              input logic [7:0] er, er2, fc, input logic st);
    vec_t v;
    v.en = e; v.clr = c; v.s = si; v.r = ri; v.q = qi; v.qbar = qbi;
    v.known = k; v.pred = p; v.mism = m; v.compl = ce; v.forb = f;
    v.err = er; v.err2 = er2; v.fcnt = fc; v.sticky = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, c, si, ri, qi, qbi);
    @(negedge clk);
    en = e; clr = c; s = si; r = ri; q = qi; qbar = qbi;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.en, v.clr, v.s, v.r, v.q, v.qbar);
    check($sformatf("v%0d known", idx), {7'b0, known}, {7'b0, v.known});
    if (v.known) check($sformatf("v%0d pred_q", idx), {7'b0, pred_q}, {7'b0, v.pred});
    check($sformatf("v%0d mismatch", idx), {7'b0, mismatch}, {7'b0, v.mism});
    check($sformatf("v%0d compl_err", idx), {7'b0, compl_err}, {7'b0, v.compl});
    check($sformatf("v%0d forbidden", idx), {7'b0, forbidden}, {7'b0, v.forb});
    check($sformatf("v%0d err_cnt", idx), err_cnt, v.err);
    check($sformatf("v%0d err_cnt_w2", idx), {6'b0, err_cnt2}, v.err2);
    check($sformatf("v%0d forb_cnt", idx), forb_cnt, v.fcnt);
    check($sformatf("v%0d forb_cnt_w2", idx), {6'b0, forb_cnt2}, v.fcnt);
    check($sformatf("v%0d sticky_err", idx), {7'b0, sticky_err}, {7'b0, v.sticky});
  endtask

  vec_t vecs[$];

  initial begin
    // en clr s r q qb | known pred mism compl forb err err2 fcnt sticky
    // Correct flip-flop through (0,0),(0,1),(1,0),(1,1).
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1,  1, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0,  0, 1, 0, 0, 1,  0, 0, 1, 0));
    // q=qbar=1 right after forbidden: no complement error.
    vecs.push_back(mk(1, 0, 0, 0, 1, 1,  0, 1, 0, 0, 0,  0, 0, 1, 0));
    // Set, then wrong q on the next edge.
    vecs.push_back(mk(1, 0, 1, 0, 1, 0,  1, 1, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0,  1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0,  1, 1, 1, 1));
    // q=qbar=1 while KNOWN.
    vecs.push_back(mk(1, 0, 0, 0, 1, 1,  1, 1, 0, 1, 0,  1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0,  1, 1, 1, 1));
    // en=0: everything holds despite S=R=1 and q==qbar.
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0,  1, 1, 1, 1));
    // clr still acts with en=0.
    vecs.push_back(mk(0, 1, 0, 0, 1, 0,  1, 1, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0,  0, 0, 0, 0));
    // Five consecutive mismatches: 8-bit counts on, 2-bit saturates at 3.
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0,  1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0,  2, 2, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0,  3, 3, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0,  4, 3, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0,  5, 3, 0, 1));
    // clr on a mismatch edge: pulse still fires, counts and sticky cleared.
    vecs.push_back(mk(1, 1, 0, 0, 0, 1,  1, 1, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0,  0, 0, 0, 0));
    // Back-to-back forbidden commands.
    vecs.push_back(mk(1, 0, 1, 1, 0, 1,  0, 0, 0, 0, 1,  0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1,  0, 0, 2, 0));

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; s = 1'b0; r = 1'b0; q = 1'b0; qbar = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset known", {7'b0, known}, 8'd0);
    check("reset pred_q", {7'b0, pred_q}, 8'd0);
    check("reset pulses", {5'b0, mismatch, compl_err, forbidden}, 8'd0);
    check("reset err_cnt", err_cnt, 8'd0);
    check("reset forb_cnt", forb_cnt, 8'd0);
    check("reset sticky_err", {7'b0, sticky_err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reach KNOWN with err_cnt=2, then reset asynchronously mid-cycle.
    drive(1, 0, 1, 0, 0, 0);
    check("pre-rst known", {7'b0, known}, 8'd1);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    check("pre-rst err_cnt", err_cnt, 8'd2);
    check("pre-rst mismatch", {7'b0, mismatch}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst known", {7'b0, known}, 8'd0);
    check("async rst pred_q", {7'b0, pred_q}, 8'd0);
    check("async rst pulses", {5'b0, mismatch, compl_err, forbidden}, 8'd0);
    check("async rst err_cnt", err_cnt, 8'd0);
    check("async rst err_cnt_w2", {6'b0, err_cnt2}, 8'd0);
    check("async rst forb_cnt", forb_cnt, 8'd0);
    check("async rst sticky_err", {7'b0, sticky_err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release: UNKNOWN, so q=1 is not a mismatch.
    drive(1, 0, 0, 0, 1, 0);
    check("post-rst mismatch", {7'b0, mismatch}, 8'd0);
    check("post-rst known", {7'b0, known}, 8'd0);
    check("post-rst compl_err", {7'b0, compl_err}, 8'd0);
    // Complement check is live in UNKNOWN.
    drive(1, 0, 0, 0, 0, 0);
    check("unknown compl_err", {7'b0, compl_err}, 8'd1);
    check("unknown mismatch", {7'b0, mismatch}, 8'd0);
    check("unknown sticky_err", {7'b0, sticky_err}, 8'd1);
    check("unknown err_cnt", err_cnt, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
